// File: rtl/reg_lock_tracker.sv
// Purpose: per-register pending-write scoreboard feeding the launcher's locks vector.
// Latency: a lock or writeback accepted at edge N shows on locks_o/outstanding_o from cycle N+1.
// Backpressure: lock_ready_o drops while NUM_OUTSTANDING writes are pending; writebacks are always accepted.
module reg_lock_tracker #(
  parameter int NUM_REGS        = 32,
  parameter int NUM_OUTSTANDING = 4,
  localparam int RW = $clog2(NUM_REGS),
  localparam int CW = $clog2(NUM_OUTSTANDING + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                lock_valid_i,
  input  logic [RW-1:0]       lock_rd_i,
  output logic                lock_ready_o,
  input  logic                wb_valid_i,
  input  logic [RW-1:0]       wb_rd_i,
  output logic                wb_ready_o,
  output logic [NUM_REGS-1:0] locks_o,
  output logic [CW-1:0]       outstanding_o,
  output logic                err_o
);

  localparam logic [CW-1:0] MAX_OUT = CW'(NUM_OUTSTANDING);

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic [CW-1:0] total_q, total_d;
  logic          err_q, err_d;

  logic lock_fire;
  logic wb_fire;
  logic wb_hit;

  // Outputs come straight from registered state; writeback side never stalls.
  assign lock_ready_o  = (total_q < MAX_OUT);
  assign wb_ready_o    = 1'b1;
  assign outstanding_o = total_q;
  assign err_o         = err_q;

  // Register r is locked while it has at least one pending write.
  always_comb begin
    locks_o = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      locks_o[r] = (cnt_q[r] != '0);
    end
  end

  // Handshakes targeting x0 complete but never touch the counters.
  assign lock_fire = lock_valid_i & lock_ready_o & (lock_rd_i != '0);
  assign wb_fire   = wb_valid_i & wb_ready_o & (wb_rd_i != '0);
  // A writeback only decrements a register that actually has a pending write.
  assign wb_hit    = wb_fire & (cnt_q[wb_rd_i] != '0);

  // Next-state: per-register counts, running total, sticky underflow flag.
  always_comb begin
    total_d = total_q + CW'(lock_fire) - CW'(wb_hit);
    err_d   = err_q | (wb_fire & ~wb_hit);
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r]
               + CW'(lock_fire && (lock_rd_i == RW'(r)))
               - CW'(wb_hit && (wb_rd_i == RW'(r)));
    end
    if (clear_i) begin
      // Flush drops every lock and any same-cycle traffic, but keeps the error history.
      total_d = '0;
      err_d   = err_q;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_d[r] = '0;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      total_q <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      total_q <= total_d;
      err_q   <= err_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Sum of per-register counts, used only to cross-check the running total.
  int cnt_sum;
  always_comb begin
    cnt_sum = 0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_sum = cnt_sum + int'(cnt_q[r]);
    end
  end

  a_total_matches_sum: assert property (@(posedge clk_i) disable iff (rst_i)
    int'(total_q) == cnt_sum);
  a_x0_never_locked: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q[0] == '0);
  a_no_lock_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !lock_ready_o |-> !lock_fire);

endmodule

// File: tb/tb_reg_lock_tracker.sv
module tb_reg_lock_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        clear_i = 1'b0;
  logic        lock_valid_i = 1'b0;
  logic [4:0]  lock_rd_i = '0;
  logic        lock_ready_o;
  logic        wb_valid_i = 1'b0;
  logic [4:0]  wb_rd_i = '0;
  logic        wb_ready_o;
  logic [31:0] locks_o;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Scoreboard queues: due cycle, expected snapshot, check name.
  int          q_cyc  [$];
  logic [37:0] q_val  [$];
  string       q_name [$];

  reg_lock_tracker #(.NUM_REGS(32), .NUM_OUTSTANDING(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .lock_valid_i (lock_valid_i),
    .lock_rd_i    (lock_rd_i),
    .lock_ready_o (lock_ready_o),
    .wb_valid_i   (wb_valid_i),
    .wb_rd_i      (wb_rd_i),
    .wb_ready_o   (wb_ready_o),
    .locks_o      (locks_o),
    .outstanding_o(outstanding_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: compare DUT state against queued expectations on the falling edge.
  always @(negedge clk_i) begin
    logic [37:0] act;
    act = {locks_o, outstanding_o, lock_ready_o, wb_ready_o, err_o};
    while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
      total++;
      if (q_cyc[0] < cyc) begin
        bad++;
        $display("FAIL %s: check missed (due cycle %0d, now %0d)", q_name[0], q_cyc[0], cyc);
      end else if (act !== q_val[0]) begin
        bad++;
        $display("FAIL %s: got locks=%h outst=%0d lrdy=%b wrdy=%b err=%b, want locks=%h outst=%0d lrdy=%b wrdy=%b err=%b",
                 q_name[0], act[37:6], act[5:3], act[2], act[1], act[0],
                 q_val[0][37:6], q_val[0][5:3], q_val[0][2], q_val[0][1], q_val[0][0]);
      end
      void'(q_cyc.pop_front());
      void'(q_val.pop_front());
      void'(q_name.pop_front());
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Queue the state expected during the current cycle (after the last edge).
  task automatic expect_state(input string n, input logic [31:0] l, input int o,
                              input logic lr, input logic e);
    q_cyc.push_back(cyc);
    q_val.push_back({l, 3'(o), lr, 1'b1, e});
    q_name.push_back(n);
  endtask

  task automatic do_lock(input int rd);
    lock_valid_i = 1'b1;
    lock_rd_i    = 5'(rd);
    step();
    lock_valid_i = 1'b0;
  endtask

  task automatic do_wb(input int rd);
    wb_valid_i = 1'b1;
    wb_rd_i    = 5'(rd);
    step();
    wb_valid_i = 1'b0;
  endtask

  initial begin
    // 1. Reset and idle
    step(); expect_state("reset_e1", 32'h0, 0, 1'b1, 1'b0);
    step(); expect_state("reset_e2", 32'h0, 0, 1'b1, 1'b0);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); expect_state("idle", 32'h0, 0, 1'b1, 1'b0);
    end

    // 2. Single lock/release
    do_lock(5); expect_state("lock5", 32'h20, 1, 1'b1, 1'b0);
    step();     expect_state("lock5_hold1", 32'h20, 1, 1'b1, 1'b0);
    step();     expect_state("lock5_hold2", 32'h20, 1, 1'b1, 1'b0);
    do_wb(5);   expect_state("wb5", 32'h0, 0, 1'b1, 1'b0);

    // 3. Fill and back-pressure
    do_lock(1); expect_state("fill1", 32'h02, 1, 1'b1, 1'b0);
    do_lock(2); expect_state("fill2", 32'h06, 2, 1'b1, 1'b0);
    do_lock(3); expect_state("fill3", 32'h0E, 3, 1'b1, 1'b0);
    do_lock(3); expect_state("fill4_full", 32'h0E, 4, 1'b0, 1'b0);
    lock_valid_i = 1'b1; lock_rd_i = 5'd7;
    step(); expect_state("full_hold_rd7_a", 32'h0E, 4, 1'b0, 1'b0);
    step(); expect_state("full_hold_rd7_b", 32'h0E, 4, 1'b0, 1'b0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd3;
    step(); expect_state("full_wb3", 32'h0E, 3, 1'b1, 1'b0);
    wb_valid_i = 1'b0;
    step(); expect_state("rd7_accepted", 32'h8E, 4, 1'b0, 1'b0);
    lock_valid_i = 1'b0;
    do_wb(1); expect_state("drain1", 32'h8C, 3, 1'b1, 1'b0);
    do_wb(2); expect_state("drain2", 32'h88, 2, 1'b1, 1'b0);
    do_wb(3); expect_state("drain3", 32'h80, 1, 1'b1, 1'b0);
    do_wb(7); expect_state("drain7", 32'h00, 0, 1'b1, 1'b0);

    // 4. Simultaneous lock and wb on the same register
    do_lock(9); expect_state("lock9", 32'h200, 1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      lock_valid_i = 1'b1; lock_rd_i = 5'd9;
      wb_valid_i = 1'b1;   wb_rd_i = 5'd9;
      step();
      lock_valid_i = 1'b0; wb_valid_i = 1'b0;
      expect_state("same_reg_lock_wb9", 32'h200, 1, 1'b1, 1'b0);
    end
    do_wb(9); expect_state("wb9", 32'h0, 0, 1'b1, 1'b0);

    // 5. x0 and underflow
    do_lock(0); expect_state("lock_x0", 32'h0, 0, 1'b1, 1'b0);
    do_wb(0);   expect_state("wb_x0", 32'h0, 0, 1'b1, 1'b0);
    do_wb(12);  expect_state("underflow12", 32'h0, 0, 1'b1, 1'b1);
    step();     expect_state("err_sticky", 32'h0, 0, 1'b1, 1'b1);

    // 6. Flush and reset mid-operation
    do_lock(1); expect_state("pre_clr1", 32'h02, 1, 1'b1, 1'b1);
    do_lock(2); expect_state("pre_clr2", 32'h06, 2, 1'b1, 1'b1);
    do_lock(3); expect_state("pre_clr3", 32'h0E, 3, 1'b1, 1'b1);
    clear_i = 1'b1; lock_valid_i = 1'b1; lock_rd_i = 5'd4;
    step();
    clear_i = 1'b0; lock_valid_i = 1'b0;
    expect_state("clear_with_lock4", 32'h0, 0, 1'b1, 1'b1);
    do_lock(5); expect_state("relock5", 32'h20, 1, 1'b1, 1'b1);
    do_lock(6); expect_state("relock6", 32'h60, 2, 1'b1, 1'b1);
    rst_i = 1'b1; lock_valid_i = 1'b1; lock_rd_i = 5'd8;
    step();
    rst_i = 1'b0; lock_valid_i = 1'b0;
    expect_state("mid_reset", 32'h0, 0, 1'b1, 1'b0);
    step(); expect_state("post_reset_idle", 32'h0, 0, 1'b1, 1'b0);

    // Let the monitor drain, then make sure nothing was left unchecked.
    step(); step();
    total++;
    if (q_cyc.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries pending, want 0", q_cyc.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_lock_tracker.md
Name: reg_lock_tracker

Overview:
Register scoreboard that produces the per-register `locks` vector consumed by the instruction launcher.
- Lock side: each accepted launch with a destination register increments a lock count for that register.
- Writeback side: each accepted writeback decrements it.
- Bounds the total number of outstanding writes to NUM_OUTSTANDING.
- Sits between the launcher's output handshake and the execution units' writeback bus.

Parameters:
NUM_REGS, 32, number of architectural registers; RW = $clog2(NUM_REGS)
NUM_OUTSTANDING, 4, max in-flight register writes; CW = $clog2(NUM_OUTSTANDING+1)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous, active-high reset
clear_i  in  1  pipeline flush, synchronous, drops all locks
lock_valid_i  in  1  launcher presents a launched instruction's destination
lock_rd_i  in  RW  destination register of launched instruction
lock_ready_o  out  1  tracker can accept a new lock
wb_valid_i  in  1  execution unit presents a completed write
wb_rd_i  in  RW  register being written back
wb_ready_o  out  1  tracker can accept a writeback
locks_o  out  NUM_REGS  bit r = 1 while register r has ≥1 pending write
outstanding_o  out  CW  total pending writes
err_o  out  1  sticky: writeback to an unlocked register

Behaviour:
- Reset: one clock, synchronous, active-high. clk_i and rst_i are fixed as decided.
- State:
  - cnt[r], CW bits per register.
  - total, CW bits.
  - err, 1 bit.
- Reset values (all from the first rising edge with rst_i=1):
  - cnt[*]=0, total=0, err=0.
  - Outputs: locks_o=0, outstanding_o=0, lock_ready_o=1, wb_ready_o=1, err_o=0.
- rst_i has priority over clear_i and over all handshakes.
- Reset asserted mid-operation discards every count in one cycle.
- Output derivation (all purely from registered state; no combinational input→output paths):
  - lock_ready_o = (total < NUM_OUTSTANDING).
  - wb_ready_o = 1 whenever rst_i is low.
  - locks_o[r] = (cnt[r] != 0).
  - outstanding_o = total.
  - err_o = err.
- Fire conditions:
  - lock_fire = lock_valid_i & lock_ready_o & (lock_rd_i != 0).
  - wb_fire = wb_valid_i & wb_ready_o & (wb_rd_i != 0).
- Register 0 is never locked. A handshake with rd=0 completes (ready honoured) and has no effect on state.
- Latency: a fire at edge N is visible on locks_o and outstanding_o after edge N (i.e. in cycle N+1). There is no same-cycle bypass.
- Per-register update each edge:
  - cnt[r] += (lock_fire & lock_rd_i==r).
  - cnt[r] -= (wb_fire & wb_rd_i==r & cnt[r]!=0).
- Simultaneous lock and wb to the same register: net 0 change, locks_o[r] unchanged.
- Total update:
  - total += lock_fire.
  - total -= effective wb decrement.
- Full boundary:
  - When total==NUM_OUTSTANDING, lock_ready_o=0 and lock_valid_i is held off.
  - A wb in that same cycle frees a slot only from the next cycle.
- Underflow:
  - A wb_fire with cnt[wb_rd_i]==0 leaves cnt and total unchanged and sets err=1.
  - err clears only on rst_i.
- Overflow: cnt[r] cannot exceed NUM_OUTSTANDING because total bounds it. No saturation logic is needed beyond the total check.
- clear_i (when rst_i=0):
  - Next state is cnt[*]=0, total=0.
  - Any lock or wb in the same cycle is discarded.
  - err is kept.
- Multiple pending writes to one register: the lock holds until the last matching writeback.
- Assertions (simulation only):
  - total == sum(cnt[r]).
  - cnt[0]==0.
  - lock_ready_o==0 implies no lock_fire.

Test Plan:
1. Reset and idle: hold rst_i=1 for 2 cycles, then release → locks_o=0, outstanding_o=0, lock_ready_o=1, wb_ready_o=1, err_o=0. Idle for 10 cycles → no change.
2. Single lock/release: lock rd=5 at edge N → locks_o=0x20, outstanding_o=1 from N+1. wb rd=5 at edge N+3 → locks_o=0, outstanding_o=0 from N+4.
3. Fill and back-pressure:
   - Lock rd=1,2,3,3 on consecutive cycles → outstanding_o=4, lock_ready_o=0, locks_o=0x0E.
   - Hold lock_valid_i=1 with rd=7 → not accepted while full.
   - wb rd=3 → outstanding_o=3, locks_o still 0x0E, lock_ready_o=1 the next cycle, then rd=7 is accepted.
4. Simultaneous same-register: with cnt[9]=1, lock rd=9 and wb rd=9 in the same cycle → locks_o[9] stays 1, outstanding_o stays 1.
5. x0 and underflow:
   - Lock rd=0 → outstanding_o unchanged, locks_o[0]=0.
   - wb rd=12 with no lock → err_o=1 next cycle and stays 1; outstanding_o unchanged.
6. Flush and reset mid-operation:
   - With 3 locks pending, pulse clear_i alongside lock rd=4 → locks_o=0, outstanding_o=0, err_o retained.
   - Re-lock 2 registers, then assert rst_i → all outputs return to their reset values after one edge.
